// File: rtl/button_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner_pkg
//  Description : Shared types and constants for the push-button front-end:
//                per-channel FSM encoding, default timing values and the
//                counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_conditioner_pkg;

    // Per-channel debounce state
    typedef enum logic [1:0] {
        BTN_RELEASED    = 2'd0,
        BTN_ARM_PRESS   = 2'd1,
        BTN_HELD        = 2'd2,
        BTN_ARM_RELEASE = 2'd3
    } btn_state_t;

    // Defaults for a 50 MHz board clock
    localparam int C_N_BTN_DEFAULT        = 4;
    localparam int C_DEBOUNCE_DEFAULT     = 1_000_000;   // 20 ms
    localparam int C_REPEAT_DELAY_DEFAULT = 25_000_000;  // 500 ms
    localparam int C_REPEAT_RATE_DEFAULT  = 5_000_000;   // 100 ms

    // Bits needed to hold 0..max_val; never less than one bit
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_conditioner_channel.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner_channel
//  Description : One button: 2-FF synchroniser, debounce FSM and auto-repeat
//                timer. Produces a clean level plus press/release/repeat
//                single-cycle strobes, all registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_DEFAULT,
    parameter int REPEAT_DELAY    = C_REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_RATE     = C_REPEAT_RATE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_n,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RW = cnt_width(REPEAT_DELAY);

    localparam logic [DW-1:0] c_dcnt_one  = DW'(1);
    localparam logic [DW-1:0] c_dcnt_last = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] c_rcnt_one  = RW'(1);
    localparam logic [RW-1:0] c_rcnt_last = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    // After a tick, restart far enough along that the next tick is REPEAT_RATE
    // cycles away; a rate longer than the delay degrades to the delay.
    localparam logic [RW-1:0] c_rcnt_reload =
        RW'((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY - REPEAT_RATE : 0);
    localparam bit c_repeat_en = (REPEAT_DELAY > 0);
    localparam bit c_deb_one   = (DEBOUNCE_CYCLES == 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          w_pressed;
    btn_state_t    r_state;
    logic [DW-1:0] r_dcnt;
    logic [RW-1:0] r_rcnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_repeat;

    // Two-flop synchroniser; resets to the released (high) pin level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= btn_raw_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = ~r_sync2;

    // Debounce FSM with repeat timer; strobes default low every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= BTN_RELEASED;
            r_dcnt    <= '0;
            r_rcnt    <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            case (r_state)
                BTN_RELEASED: begin
                    if (w_pressed) begin
                        if (c_deb_one) begin
                            r_state <= BTN_HELD;
                            r_press <= 1'b1;
                            r_level <= 1'b1;
                            r_rcnt  <= '0;
                        end else begin
                            r_state <= BTN_ARM_PRESS;
                            r_dcnt  <= c_dcnt_one;
                        end
                    end
                end
                BTN_ARM_PRESS: begin
                    if (!w_pressed) begin
                        r_state <= BTN_RELEASED;
                        r_dcnt  <= '0;
                    end else if (r_dcnt == c_dcnt_last) begin
                        r_state <= BTN_HELD;
                        r_press <= 1'b1;
                        r_level <= 1'b1;
                        r_rcnt  <= '0;
                        r_dcnt  <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + c_dcnt_one;
                    end
                end
                BTN_HELD: begin
                    if (!w_pressed) begin
                        if (c_deb_one) begin
                            r_state   <= BTN_RELEASED;
                            r_release <= 1'b1;
                            r_level   <= 1'b0;
                        end else begin
                            r_state <= BTN_ARM_RELEASE;
                            r_dcnt  <= c_dcnt_one;
                        end
                    end else if (c_repeat_en) begin
                        if (r_rcnt == c_rcnt_last) begin
                            r_repeat <= 1'b1;
                            r_rcnt   <= c_rcnt_reload;
                        end else begin
                            r_rcnt <= r_rcnt + c_rcnt_one;
                        end
                    end
                end
                BTN_ARM_RELEASE: begin
                    // Repeat timer holds its value here so a rejected bounce resumes it
                    if (w_pressed) begin
                        r_state <= BTN_HELD;
                        r_dcnt  <= '0;
                    end else if (r_dcnt == c_dcnt_last) begin
                        r_state   <= BTN_RELEASED;
                        r_release <= 1'b1;
                        r_level   <= 1'b0;
                        r_dcnt    <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + c_dcnt_one;
                    end
                end
                default: begin
                    r_state <= BTN_RELEASED;
                end
            endcase
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign btn_repeat  = r_repeat;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Push-button front-end. Instances one independent
//                conditioning channel per button and packs their outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N_BTN           = C_N_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_DEFAULT,
    parameter int REPEAT_DELAY    = C_REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_RATE     = C_REPEAT_RATE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    generate
        for (genvar g = 0; g < N_BTN; g++) begin : g_chan
            button_conditioner_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_RATE     (REPEAT_RATE)
            ) u_chan (
                .clk         (clk),
                .rst_n       (rst_n),
                .btn_raw_n   (btn_raw_n[g]),
                .btn_level   (btn_level[g]),
                .btn_press   (btn_press[g]),
                .btn_release (btn_release[g]),
                .btn_repeat  (btn_repeat[g])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Directed self-checking bench for button_conditioner with
//                short timing (debounce 4, repeat delay 10, repeat rate 3).
//                Outputs are logged every cycle; checks read the log.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int LOG_N = 1024;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_raw_n;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_repeat;

    int n_checks;
    int n_fail;
    int cyc;

    logic [3:0] log_press   [LOG_N];
    logic [3:0] log_release [LOG_N];
    logic [3:0] log_repeat  [LOG_N];
    logic [3:0] log_level   [LOG_N];

    button_conditioner #(
        .N_BTN           (4),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw_n   (btn_raw_n),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Log[i] holds the outputs produced by posedge number i
    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            log_press[cyc]   = btn_press;
            log_release[cyc] = btn_release;
            log_repeat[cyc]  = btn_repeat;
            log_level[cyc]   = btn_level;
        end
    end

    task automatic check_value(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] log_vec(input int kind, input int i);
        case (kind)
            0:       return log_press[i];
            1:       return log_release[i];
            2:       return log_repeat[i];
            default: return log_level[i];
        endcase
    endfunction

    function automatic int hit(input int kind, input int i, input int ch);
        logic [3:0] v;
        v = log_vec(kind, i);
        return (v[ch] === 1'b1) ? 1 : 0;
    endfunction

    function automatic int first_hit(input int kind, input int ch, input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            if (hit(kind, i, ch) == 1) return i;
        return -1;
    endfunction

    function automatic int count_hits(input int kind, input int ch, input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) n += hit(kind, i, ch);
        return n;
    endfunction

    function automatic int first_vec(input int kind, input logic [3:0] val, input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            if (log_vec(kind, i) === val) return i;
        return -1;
    endfunction

    function automatic int count_nonzero(input int kind, input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++)
            if (log_vec(kind, i) !== 4'b0000) n++;
        return n;
    endfunction

    // Hard stop if the sequence ever stalls
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        int e2;
        int p;
        int both;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < LOG_N; i++) begin
            log_press[i]   = '0;
            log_release[i] = '0;
            log_repeat[i]  = '0;
            log_level[i]   = '0;
        end

        // 1: reset with every button held, then release reset
        rst_n     = 1'b0;
        btn_raw_n = 4'b0000;
        wait_cyc(3);
        check_value("rst_level",   btn_level,   0);
        check_value("rst_press",   btn_press,   0);
        check_value("rst_release", btn_release, 0);
        check_value("rst_repeat",  btn_repeat,  0);
        rst_n = 1'b1;
        e = cyc;
        wait_cyc(12);
        check_value("t1_press_lat", first_vec(0, 4'b1111, e + 1, e + 12) - e, 6);
        check_value("t1_press_cycles", count_nonzero(0, e + 1, e + 12), 1);
        check_value("t1_level", btn_level, 15);
        btn_raw_n = 4'b1111;
        e = cyc;
        wait_cyc(12);
        check_value("t1_release_lat", first_vec(1, 4'b1111, e + 1, e + 12) - e, 6);
        check_value("t1_level_off", btn_level, 0);

        // 2: clean press and release on ch0
        btn_raw_n[0] = 1'b0;
        e = cyc;
        wait_cyc(20);
        btn_raw_n[0] = 1'b1;
        e2 = cyc;
        wait_cyc(12);
        check_value("t2_press_lat", first_hit(0, 0, e + 1, e2) - e, 6);
        check_value("t2_press_cnt", count_hits(0, 0, e + 1, e2 + 12), 1);
        check_value("t2_level_before", hit(3, e + 5, 0), 0);
        check_value("t2_level_at", hit(3, e + 6, 0), 1);
        check_value("t2_release_lat", first_hit(1, 0, e2 + 1, e2 + 12) - e2, 6);
        check_value("t2_release_cnt", count_hits(1, 0, e + 1, e2 + 12), 1);
        check_value("t2_level_end", btn_level, 0);
        check_value("t2_other_press", count_hits(0, 1, e + 1, e2 + 12) +
                    count_hits(0, 2, e + 1, e2 + 12) + count_hits(0, 3, e + 1, e2 + 12), 0);

        // 3: bounce on ch1 (low 3, high 1, low 2, high)
        e = cyc;
        btn_raw_n[1] = 1'b0;
        wait_cyc(3);
        btn_raw_n[1] = 1'b1;
        wait_cyc(1);
        btn_raw_n[1] = 1'b0;
        wait_cyc(2);
        btn_raw_n[1] = 1'b1;
        wait_cyc(12);
        check_value("t3_press",   count_hits(0, 1, e + 1, e + 18), 0);
        check_value("t3_release", count_hits(1, 1, e + 1, e + 18), 0);
        check_value("t3_level",   count_hits(3, 1, e + 1, e + 18), 0);

        // 4: auto-repeat on ch2 held 30 cycles
        btn_raw_n[2] = 1'b0;
        e = cyc;
        wait_cyc(30);
        btn_raw_n[2] = 1'b1;
        wait_cyc(12);
        p = e + 6;
        check_value("t4_press_lat", first_hit(0, 2, e + 1, e + 42) - e, 6);
        for (int k = 0; k < 6; k++)
            check_value($sformatf("t4_rep%0d", k), hit(2, p + 10 + 3 * k, 2), 1);
        check_value("t4_rep_cnt", count_hits(2, 2, e + 1, e + 42), 6);
        both = 0;
        for (int i = e + 1; i <= e + 42; i++)
            if (hit(0, i, 2) == 1 && hit(2, i, 2) == 1) both++;
        check_value("t4_press_rep_overlap", both, 0);
        check_value("t4_release_lat", first_hit(1, 2, e + 31, e + 42) - (e + 30), 6);

        // 5a: ch0 and ch3 pressed on the same cycle
        btn_raw_n = 4'b0110;
        e = cyc;
        wait_cyc(12);
        check_value("t5_simul_press", first_vec(0, 4'b1001, e + 1, e + 12) - e, 6);
        // 5b: async reset while ch0 held and ch1 still debouncing
        btn_raw_n = 4'b1110;
        wait_cyc(12);
        btn_raw_n = 4'b1100;
        wait_cyc(4);
        check_value("t5_pre_level", btn_level, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("t5_async_level", btn_level, 0);
        check_value("t5_async_strobes", {btn_press, btn_release, btn_repeat}, 0);
        btn_raw_n = 4'b1111;
        wait_cyc(3);
        rst_n = 1'b1;
        e = cyc;
        wait_cyc(12);
        check_value("t5_no_press",   count_nonzero(0, e - 3, e + 12), 0);
        check_value("t5_no_release", count_nonzero(1, e - 3, e + 12), 0);
        check_value("t5_level_end",  btn_level, 0);

        // 6: one-cycle release bounce on ch3 while held
        btn_raw_n[3] = 1'b0;
        e = cyc;
        wait_cyc(8);
        btn_raw_n[3] = 1'b1;
        wait_cyc(1);
        btn_raw_n[3] = 1'b0;
        wait_cyc(20);
        btn_raw_n[3] = 1'b1;
        wait_cyc(12);
        p = e + 6;
        check_value("t6_level_held", count_hits(3, 3, p, e + 34), e + 34 - p + 1);
        check_value("t6_release_cnt", count_hits(1, 3, e + 1, e + 41), 1);
        check_value("t6_release_lat", first_hit(1, 3, e + 1, e + 41) - (e + 29), 6);
        check_value("t6_first_rep", first_hit(2, 3, p, e + 41) - p, 12);
        check_value("t6_second_rep", hit(2, p + 15, 3), 1);
        check_value("t6_rep_cnt", count_hits(2, 3, e + 1, e + 41), 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
